// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
//   LOAD_START     : frame start marker byte
//   INSTR_MEM_NUM  : instruction memory depth in words
//   INSTR_MEM_BW   : word-address width
//   ld_state_e     : loader FSM state encoding (3-bit)
package instr_mem_loader_pkg;

  localparam logic [7:0] LOAD_START    = 8'hA5;
  localparam int         INSTR_MEM_NUM = 64;
  localparam int         INSTR_MEM_BW  = 6;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_COUNT = 3'd1,
    LD_DATA  = 3'd2,
    LD_CSUM  = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input, memory write port and status lines of the loader.
//   byte_valid/byte_data : host byte stream (no backpressure)
//   mem_we/waddr/wdata   : instruction memory word write port
//   cpu_hold             : keeps the core stalled while high
//   load_done/load_err   : status of the last frame
// Modports: master = host/bench side, slave = loader side.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 6
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output byte_valid, byte_data,
    input  mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  byte_valid, byte_data,
    output mem_we, mem_waddr, mem_wdata, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// Big-endian word assembler: collects bytes into a 32-bit word.
//   i_clk, i_rst   : clock, async active-high reset
//   i_clr          : restart byte position at the first byte of a word
//   i_en           : accept i_byte this cycle
//   i_byte         : data byte
//   o_word_valid   : combinational; high while the 4th byte of a word is accepted
//   o_word         : combinational; the completed word (valid with o_word_valid)
module word_assembler (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  // The 4th byte bypasses the shift register so the top can register the
  // write on the same edge that accepts it.
  assign o_word_valid = i_en && (r_cnt == 2'd3);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-serial instruction memory programming controller.
// Parses frames  A5, N, 4*N data bytes, XOR checksum  and writes big-endian
// words to the instruction memory; holds the CPU until a frame loads cleanly.
//   sys_clk   : clock, rising edge
//   sys_reset : asynchronous active-high reset
//   bus       : byte stream in, memory write port and status out (slave)
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = INSTR_MEM_NUM,
  parameter int ADDR_W = INSTR_MEM_BW
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  instr_mem_loader_if.slave  bus
);

  // One extra bit so that N = DEPTH is representable and terminates the load.
  localparam int CNT_W = ADDR_W + 1;

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_widx;
  logic [CNT_W-1:0]  w_widx_nxt;
  logic [7:0]        r_csum;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_done;
  logic              r_err;
  logic              w_start;
  logic              w_cnt_byte;
  logic              w_asm_en;
  logic              w_word_valid;
  logic [31:0]       w_word;

  // Count byte 0 means a full memory; anything above DEPTH saturates.
  function automatic logic [CNT_W-1:0] sat_count(input logic [7:0] b);
    if ((b == 8'd0) || (int'(b) > DEPTH)) return CNT_W'(DEPTH);
    return CNT_W'(b);
  endfunction

  assign w_start    = bus.byte_valid && (bus.byte_data == LOAD_START);
  assign w_cnt_byte = bus.byte_valid && (r_state == LD_COUNT);
  assign w_asm_en   = bus.byte_valid && (r_state == LD_DATA);
  assign w_widx_nxt = r_widx + CNT_W'(1);

  word_assembler u_asm (
    .i_clk        (sys_clk),
    .i_rst        (sys_reset),
    .i_clr        (w_cnt_byte),
    .i_en         (w_asm_en),
    .i_byte       (bus.byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) r_state <= LD_IDLE;
    else           r_state <= w_next;
  end

  // A5 only restarts from IDLE/DONE/ERR; inside a frame it is plain data.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LD_IDLE, LD_DONE, LD_ERR: if (w_start) w_next = LD_COUNT;
      LD_COUNT: if (bus.byte_valid) w_next = LD_DATA;
      LD_DATA:  if (w_word_valid && (w_widx_nxt == r_n)) w_next = LD_CSUM;
      LD_CSUM:  if (bus.byte_valid)
                  w_next = (bus.byte_data == r_csum) ? LD_DONE : LD_ERR;
      default:  w_next = LD_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_n     <= '0;
      r_widx  <= '0;
      r_csum  <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_word_valid;
      if (w_word_valid) begin
        r_waddr <= r_widx[ADDR_W-1:0];
        r_wdata <= w_word;
        r_widx  <= w_widx_nxt;
      end
      if (w_cnt_byte) begin
        r_n    <= sat_count(bus.byte_data);
        r_widx <= '0;
        r_csum <= '0;
      end
      if (w_asm_en) r_csum <= r_csum ^ bus.byte_data;
      // Status follows the state register by one edge.
      r_hold <= (r_state != LD_DONE);
      r_done <= (r_state == LD_DONE);
      r_err  <= (r_state == LD_ERR);
    end
  end

  assign bus.mem_we    = r_we;
  assign bus.mem_waddr = r_waddr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_hold  = r_hold;
  assign bus.load_done = r_done;
  assign bus.load_err  = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: frames are built at frame level,
// expected writes/status are derived from the frame contents and compared
// with what the loader produces.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic sys_clk;
  logic sys_reset;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [ADDR_W+31:0] act_q[$];
  int                 act_cyc[$];
  logic [31:0]        mem_exp[DEPTH];
  logic [31:0]        mem_act[DEPTH];
  logic [7:0]         pre_q[$];

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample #1 later and log any memory write.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (bus.mem_we === 1'b1) begin
      act_q.push_back({bus.mem_waddr, bus.mem_wdata});
      act_cyc.push_back(cyc);
      mem_act[bus.mem_waddr] = bus.mem_wdata;
    end
  endtask

  task automatic idle();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 3)) idle();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    tick();
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hold"},  64'(bus.cpu_hold),  64'(1));
    check_eq({tag, "_we"},    64'(bus.mem_we),    64'(0));
    check_eq({tag, "_waddr"}, 64'(bus.mem_waddr), 64'(0));
    check_eq({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check_eq({tag, "_done"},  64'(bus.load_done), 64'(0));
    check_eq({tag, "_err"},   64'(bus.load_err),  64'(0));
  endtask

  // csum_ovr: -1 correct checksum, -2 random wrong checksum, else literal byte.
  task automatic send_frame(input logic [7:0] cnt_b, input bit gaps, input int csum_ovr);
    int          n;
    int          last_cyc;
    logic [7:0]  d[$];
    logic [7:0]  cs;
    logic [7:0]  cb;
    logic [31:0] w;
    bit          ok;
    n = ((cnt_b == 8'd0) || (int'(cnt_b) > DEPTH)) ? DEPTH : int'(cnt_b);
    d = {};
    for (int i = 0; i < 4 * n; i++)
      d.push_back((i < pre_q.size()) ? pre_q[i] : 8'($urandom));
    cs = 8'd0;
    foreach (d[i]) cs ^= d[i];
    if (csum_ovr == -1)      cb = cs;
    else if (csum_ovr == -2) cb = cs ^ 8'($urandom_range(1, 255));
    else                     cb = 8'(csum_ovr);
    ok = (cb == cs);
    act_q.delete();
    act_cyc.delete();

    send_byte(LOAD_START, gaps);
    send_byte(cnt_b, gaps);
    check_eq("restart_hold", 64'(bus.cpu_hold),  64'(1));
    check_eq("restart_done", 64'(bus.load_done), 64'(0));
    check_eq("restart_err",  64'(bus.load_err),  64'(0));

    foreach (d[i]) send_byte(d[i], gaps);
    last_cyc = cyc;
    send_byte(cb, gaps);
    check_eq("hold_at_csum_edge", 64'(bus.cpu_hold), 64'(1));
    idle();
    check_eq("status_hold", 64'(bus.cpu_hold),  64'(!ok));
    check_eq("status_done", 64'(bus.load_done), 64'(ok));
    check_eq("status_err",  64'(bus.load_err),  64'(!ok));

    check_eq("write_count", 64'(act_q.size()), 64'(n));
    for (int i = 0; i < n && i < act_q.size(); i++) begin
      w = {d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]};
      mem_exp[i] = w;
      check_eq("write_addr", 64'(act_q[i][ADDR_W+31:32]), 64'(i));
      check_eq("write_data", 64'(act_q[i][31:0]), 64'(w));
      if (!gaps && i > 0)
        check_eq("write_spacing", 64'(act_cyc[i] - act_cyc[i-1]), 64'(4));
    end
    if (act_q.size() == n && n > 0)
      check_eq("last_write_cycle", 64'(act_cyc[n-1]), 64'(last_cyc));
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      mem_exp[i] = 32'd0;
      mem_act[i] = 32'd0;
    end
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    sys_reset      = 1'b1;
    tick();
    tick();
    check_reset_outputs("por");
    sys_reset = 1'b0;
    repeat (20) idle();
    check_eq("idle_writes", 64'(act_q.size()), 64'(0));
    check_eq("idle_hold",   64'(bus.cpu_hold),  64'(1));
    check_eq("idle_done",   64'(bus.load_done), 64'(0));

    // Directed two-word frame, good then corrupted checksums.
    pre_q = {8'h00, 8'h00, 8'h00, 8'h13, 8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(8'd2, 1'b0, -1);
    send_frame(8'd2, 1'b0, 0);
    send_frame(8'd2, 1'b0, 8'h7B);
    pre_q = {};
    send_frame(8'd3, 1'b0, -1);

    // Full memory with gaps.
    send_frame(8'd0, 1'b1, -1);

    // Reset in the middle of a frame after 6 data bytes.
    act_q.delete();
    act_cyc.delete();
    send_byte(LOAD_START, 1'b0);
    send_byte(8'd3, 1'b0);
    for (int i = 0; i < 6; i++) pre_q.push_back(8'($urandom_range(1, 255)));
    foreach (pre_q[i]) send_byte(pre_q[i], 1'b0);
    mem_exp[0] = {pre_q[0], pre_q[1], pre_q[2], pre_q[3]};
    pre_q = {};
    #2;
    sys_reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    sys_reset = 1'b0;
    check_eq("partial_writes", 64'(act_q.size()), 64'(1));
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (b == LOAD_START) b = 8'h5A;
      send_byte(b, 1'b0);
    end
    idle();
    check_eq("stray_writes", 64'(act_q.size()), 64'(1));
    check_eq("stray_hold",   64'(bus.cpu_hold),  64'(1));
    check_eq("stray_done",   64'(bus.load_done), 64'(0));
    send_frame(8'd4, 1'b0, -1);

    // Restart from DONE; A5 as count and as data stays inside the frame.
    pre_q = {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h02, 8'h03};
    send_frame(8'hA5, 1'b0, -1);
    pre_q = {};

    // Randomized frames.
    for (int f = 0; f < 6; f++)
      send_frame(8'($urandom_range(0, 255)), 1'($urandom), ($urandom_range(0, 3) == 0) ? -2 : -1);

    for (int i = 0; i < DEPTH; i++)
      check_eq("mem_image", 64'(mem_act[i]), 64'(mem_exp[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
